// File: rtl/sram_arbiter_2p.sv
// Two-port round-robin arbiter and sequencer for the 16x8 SRAM controller.
// Runs one controller transaction at a time and aborts it if done never arrives.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for a_req/b_req, picks the winner and captures its command
// ISSUE | mc_start pulse, timer cleared
// WAIT  | waiting for mc_done or watchdog expiry
// RESP  | owner done/err pulse, round-robin pointer moves to the other side
module sram_arbiter_2p #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_rw,
    input  logic [3:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_done,
    output logic       a_err,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_rw,
    input  logic [3:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_done,
    output logic       b_err,
    output logic [7:0] b_rdata,
    output logic       mc_start,
    output logic       mc_rw,
    output logic [3:0] mc_addr,
    output logic [7:0] mc_wdata,
    input  logic [7:0] mc_rdata,
    input  logic       mc_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    logic       rr_ptr;
    logic       owner;
    logic       cmd_rw;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [3:0] timer;
    logic       win_b;
    logic       active;

    // B wins when alone or when both request and the pointer favours B
    assign win_b  = b_req & (~a_req | rr_ptr);
    assign active = (state != IDLE);

    assign mc_rw    = active & cmd_rw;
    assign mc_addr  = active ? cmd_addr  : 4'h0;
    assign mc_wdata = active ? cmd_wdata : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= 4'h0;
            cmd_wdata <= 8'h00;
            timer     <= 4'h0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            a_rdata   <= 8'h00;
            b_rdata   <= 8'h00;
            mc_start  <= 1'b0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            a_err    <= 1'b0;
            b_err    <= 1'b0;
            mc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        owner     <= win_b;
                        cmd_rw    <= win_b ? b_rw    : a_rw;
                        cmd_addr  <= win_b ? b_addr  : a_addr;
                        cmd_wdata <= win_b ? b_wdata : a_wdata;
                        a_gnt     <= ~win_b;
                        b_gnt     <= win_b;
                        mc_start  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= 4'h0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mc_done) begin
                        if (owner) begin
                            b_done <= 1'b1;
                            if (cmd_rw) b_rdata <= mc_rdata;
                        end else begin
                            a_done <= 1'b1;
                            if (cmd_rw) a_rdata <= mc_rdata;
                        end
                        state <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        // watchdog expiry: read data is forced to zero
                        if (owner) begin
                            b_done <= 1'b1;
                            b_err  <= 1'b1;
                            if (cmd_rw) b_rdata <= 8'h00;
                        end else begin
                            a_done <= 1'b1;
                            a_err  <= 1'b1;
                            if (cmd_rw) a_rdata <= 8'h00;
                        end
                        state <= RESP;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                RESP: begin
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
